// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and twiddle address rule for the 32-point CORDIC FFT.
// Pure declarations: no timing and no flow control.
package fft_pkg;
  localparam int LOG2N   = 5;
  localparam int N       = 1 << LOG2N;
  localparam int NBFLY   = N / 2;
  localparam int ANGLE_W = 32;
  localparam int IDX_W   = LOG2N - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} tw_state_t;

  // addr(j) = (j mod 2^(s-1)) << (LOG2N-s); valid for s in 1..LOG2N
  function automatic logic [IDX_W-1:0] tw_addr(input logic [IDX_W-1:0] j, input logic [2:0] s);
    logic [IDX_W:0]   span;
    logic [IDX_W-1:0] mask;
    span = (IDX_W+1)'(1) << (s - 3'd1);
    mask = span[IDX_W-1:0] - {{(IDX_W-1){1'b0}}, 1'b1};
    return (j & mask) << (3'(LOG2N) - s);
  endfunction
endpackage

// File: rtl/twiddle_fetch_if.sv
// Angle stream from the twiddle reader to the CORDIC rotator (valid/ready).
// Head entry holds stable while valid is high and ready is low.
interface twiddle_fetch_if;
  import fft_pkg::*;

  logic               angle_valid;
  logic [ANGLE_W-1:0] angle;
  logic [IDX_W-1:0]   angle_idx;
  logic               angle_ready;

  modport master (output angle_valid, angle, angle_idx, input angle_ready);
  modport slave  (input angle_valid, angle, angle_idx, output angle_ready);
endinterface

// File: rtl/angle_skid_fifo.sv
// Two-entry register FIFO: a push is visible at dout one edge later; no internal flow control.
// The caller must never push into a full FIFO without popping on the same edge.
module angle_skid_fifo #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] head;
  logic [W-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new word lands behind whatever remains
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = head;
endmodule

// File: rtl/twiddle_fetch.sv
// Walks 16 butterflies of one stage, reads the twiddle ROM and streams angles; first angle 2 cycles after start.
// ROM reads are credit-limited to the 2-entry buffer, so backpressure never loses or duplicates an angle.
module twiddle_fetch
  import fft_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [2:0]         i_stage,
  output logic               o_busy,
  output logic               o_err,
  output logic [IDX_W-1:0]   o_rom_addr,
  input  logic [ANGLE_W-1:0] i_rom_data,
  output logic               o_done,
  twiddle_fetch_if.master    ang
);
  tw_state_t                  state;
  tw_state_t                  state_nxt;
  logic [2:0]                 stage_q;
  logic [IDX_W-1:0]           j_q;
  logic [IDX_W-1:0]           pend_idx;
  logic                       pend;
  logic [IDX_W:0]             pop_cnt;
  logic [1:0]                 count;
  logic [ANGLE_W+IDX_W-1:0]   head;
  logic [2:0]                 credit;
  logic                       stage_ok;
  logic                       accept;
  logic                       pop;
  logic                       issue;
  logic                       last_pop;

  assign stage_ok = (i_stage != 3'd0) && (i_stage <= 3'(LOG2N));
  assign accept   = (state == IDLE) && i_start && stage_ok;
  assign pop      = ang.angle_valid && ang.angle_ready;
  // a read may only launch if its word is guaranteed a slot when it lands
  assign credit   = 3'(count) + 3'(pend) - 3'(pop);
  assign issue    = (state == ISSUE) && (credit < 3'd2);
  assign last_pop = pop && (pop_cnt == (IDX_W+1)'(NBFLY - 1));

  assign o_rom_addr = issue ? tw_addr(j_q, stage_q) : '0;
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (issue && (j_q == IDX_W'(NBFLY - 1))) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q  <= '0;
      j_q      <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
      pop_cnt  <= '0;
      o_err    <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_err  <= (state == IDLE) && i_start && !stage_ok;
      o_done <= last_pop;
      pend   <= issue;
      if (issue) begin
        pend_idx <= j_q;
        j_q      <= j_q + IDX_W'(1);
      end
      if (accept) begin
        stage_q <= i_stage;
        j_q     <= '0;
        pop_cnt <= '0;
      end else if (pop) begin
        pop_cnt <= pop_cnt + (IDX_W+1)'(1);
      end
    end
  end

  angle_skid_fifo #(.W(ANGLE_W + IDX_W)) u_buf (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (pend),
    .pop   (pop),
    .din   ({i_rom_data, pend_idx}),
    .dout  (head),
    .count (count)
  );

  assign ang.angle_valid = (count != 2'd0);
  assign ang.angle       = head[ANGLE_W+IDX_W-1:IDX_W];
  assign ang.angle_idx   = head[IDX_W-1:0];

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(pend && !pop && (count == 2'd2)));
endmodule

// File: doc/twiddle_fetch.md
# twiddle_fetch

Twiddle-angle sequencer and reader for one radix-2 DIT butterfly stage of the 32-point CORDIC FFT. It walks the 16 butterflies of the selected stage and drives the 4-bit address into the stage twiddle ROM. The ROM has one cycle of registered read latency. A 2-entry buffer absorbs that latency so the block can present each IEEE-754 single-precision angle (radians) to the CORDIC rotator over a valid/ready handshake, without loss under backpressure.

## Interface
- LOG2N, 5, log2 of FFT length; the butterfly count is 2^(LOG2N-1) = 16.
- DW, 32, angle word width (IEEE-754 single).
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_stage  in  3  stage number, 1..LOG2N; latched on an accepted start.
- o_busy  out  1  high from the start edge until o_done.
- o_err  out  1  one-cycle pulse when a start is rejected because i_stage is invalid.
- o_rom_addr  out  LOG2N-1  ROM address; combinational from the registered butterfly counter and the credit check.
- i_rom_data  in  DW  ROM read data, valid one edge after the address is sampled.
- o_angle_valid  out  1  buffer head valid.
- o_angle  out  DW  buffer head angle.
- o_angle_idx  out  LOG2N-1  butterfly index j of the head entry.
- i_angle_ready  in  1  rotator accepts the head entry.
- o_done  out  1  one-cycle pulse after the 16th angle handshake.

## Operation
- States:
  - IDLE: accepts i_start.
  - ISSUE: issues ROM reads, one per butterfly.
  - DRAIN: all reads issued; waits for the final handshake.
- IDLE -> ISSUE when i_start=1 and 1 ≤ i_stage ≤ LOG2N. Latch s; clear j, the issue counter, and the output counter.
- Start with i_stage=0 or i_stage>LOG2N: stay in IDLE and pulse o_err. o_busy stays low.
- i_start is ignored outside IDLE.
- Address rule: addr(j) = (j mod 2^(s-1)) << (LOG2N-s), truncated to LOG2N-1 bits.
  - Stage 1: every address is 0.
  - Stage 5: addresses are 0..15.
- Issue condition: state is ISSUE and (count + pend − pop) < 2.
  - count = buffer occupancy (0..2).
  - pend = read in flight.
  - pop = o_angle_valid & i_angle_ready.
- On an issue edge:
  - pend <= 1 and the tag pend_idx <= j.
  - j increments.
  - After j=15 is issued, go to DRAIN.
- With no issue, pend <= 0. o_rom_addr = addr(j) while issuing, 0 otherwise.
- On any edge with pend=1, push {i_rom_data, pend_idx} into the buffer.
  - A push and a pop on the same edge are legal; occupancy is unchanged.
  - Push into a full buffer cannot occur because of the credit rule. An assertion checks this.
- Handshake rules:
  - o_angle_valid=1 whenever count>0.
  - While valid=1 and ready=0, the head entry (o_angle, o_angle_idx) holds stable.
  - Valid never drops without a pop.
- Completion: the 16th pop edge sets the state to IDLE and o_done=1 for one cycle. o_busy drops on the same edge.
- Reset value of every output is 0. Reset also sets state to IDLE and clears count, pend, and all counters.
- Reset asserted mid-operation aborts immediately. The buffer is discarded, and no o_done or o_err is produced.

## Timing
- Edge E0 samples i_start. o_busy=1 and o_rom_addr=addr(0) in the following cycle.
- E1: ROM captures addr(0). E2: entry 0 is pushed. o_angle_valid=1 after E2.
- First-angle latency from the start edge: 2 cycles.
- Throughput is 1 angle per cycle while i_angle_ready is held high.
- With ready held high, handshakes occur on E3..E18. o_done=1 in the cycle after E18.
- After ready is released following backpressure, the first pop occurs on the next edge. There is no bubble because the buffer holds 2 entries.

## Structure
- The shared package fft_pkg holds:
  - LOG2N, N, NBFLY = N/2, and ANGLE_W.
  - typedef tw_state_t {IDLE, ISSUE, DRAIN}.
  - The address-rule function tw_addr(j, s).
- Sub-module angle_skid_fifo: 2-entry register FIFO of {DW+LOG2N-1} bits.
  - Ports: push, pop, din, dout, count, with the same clock and reset.
  - It is a pure storage element with no flow-control policy.
- The ROM is instantiated at the stage top level, not inside this block.

## Test plan
- Stage 5, ready held high, with the ROM model attached:
  - o_rom_addr sequence is 0..15.
  - o_angle sequence runs 00000000, be490fdb, …, c03c7edd, with o_angle_idx 0..15.
  - Valid first appears after E2, and o_done is high in the cycle after E18.
- Stage 3, ready high: the address sequence is 0,4,8,12 repeated 4 times, and the angle pattern repeats accordingly.
- Stage 1: all 16 angles are 00000000 and o_done is produced.
- Stage 5 with ready low for 5 cycles starting at E3, then random toggling:
  - Exactly 16 pops in order, with no duplicates and no drops.
  - Head stays stable while stalled; count never exceeds 2.
- Start with i_stage=0, then with i_stage=6: o_err pulses once for each, o_busy stays 0, and there is no ROM activity. A start during busy is ignored.
- Assert i_rst_n=0 after 7 pops of stage 5:
  - All outputs go to 0 immediately, and there is no o_done.
  - A subsequent stage 4 start completes normally with addresses 0,2,4,…,14 repeated twice.
